// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for mem_arbiter: client IDs, arbiter state encoding,
// default burst length and a log2 helper used to size the beat address.
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef CPU_ADDR_BITS
`define CPU_ADDR_BITS 32
`endif

package mem_arbiter_pkg;

    localparam logic CLIENT_IC = 1'b0;
    localparam logic CLIENT_DC = 1'b1;

    localparam int DEFAULT_BEATS = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        WR_DATA = 1'b1
    } arb_state_t;

    function automatic int ceil_log2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// One-bit synchronous FIFO recording which client owns each outstanding read,
// oldest entry presented combinationally on head.
module mem_arb_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0] slots;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_id;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction and data caches onto one memory port, locking the
// write channel per burst and routing read beats by an in-order owner queue.
// Define MEM_ARB_RR_EN for round-robin priority; otherwise dc always wins.
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef CPU_ADDR_BITS
`define CPU_ADDR_BITS 32
`endif

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BEATS           = DEFAULT_BEATS,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = `CPU_ADDR_BITS - ceil_log2(`MEM_DATA_BITS / 8)
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        ic_req_valid,
    output logic                        ic_req_ready,
    input  logic [ADDR_W-1:0]           ic_req_addr,
    input  logic                        ic_req_rw,
    input  logic                        ic_req_data_valid,
    output logic                        ic_req_data_ready,
    input  logic [`MEM_DATA_BITS-1:0]   ic_req_data_bits,
    input  logic [`MEM_DATA_BITS/8-1:0] ic_req_data_mask,
    output logic                        ic_resp_valid,
    output logic [`MEM_DATA_BITS-1:0]   ic_resp_data,

    input  logic                        dc_req_valid,
    output logic                        dc_req_ready,
    input  logic [ADDR_W-1:0]           dc_req_addr,
    input  logic                        dc_req_rw,
    input  logic                        dc_req_data_valid,
    output logic                        dc_req_data_ready,
    input  logic [`MEM_DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [`MEM_DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                        dc_resp_valid,
    output logic [`MEM_DATA_BITS-1:0]   dc_resp_data,

    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic                        mem_req_rw,
    output logic                        mem_req_data_valid,
    input  logic                        mem_req_data_ready,
    output logic [`MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic [`MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                        mem_resp_valid,
    input  logic [`MEM_DATA_BITS-1:0]   mem_resp_data
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_t       state;
    arb_state_t       next_state;
    logic             wr_owner;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] resp_cnt;

    logic             q_full;
    logic             q_empty;
    logic             q_head;
    logic             q_push;
    logic             q_pop;

    logic             pref;
    logic             ic_elig;
    logic             dc_elig;
    logic             any_elig;
    logic             winner;
    logic             win_rw;
    logic [ADDR_W-1:0] win_addr;
    logic             req_fire;
    logic             wr_beat_fire;
    logic             resp_routed;

`ifdef MEM_ARB_RR_EN
    logic prio;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= CLIENT_DC;
        end else if (req_fire) begin
            prio <= ~prio;
        end
    end

    assign pref = prio;
`else
    assign pref = CLIENT_DC;
`endif

    // A read may only win while the owner queue has room for its ID.
    assign ic_elig  = ic_req_valid && (ic_req_rw || !q_full);
    assign dc_elig  = dc_req_valid && (dc_req_rw || !q_full);
    assign any_elig = ic_elig || dc_elig;
    assign winner   = (pref == CLIENT_DC) ? (dc_elig ? CLIENT_DC : CLIENT_IC)
                                          : (ic_elig ? CLIENT_IC : CLIENT_DC);
    assign win_rw   = (winner == CLIENT_DC) ? dc_req_rw   : ic_req_rw;
    assign win_addr = (winner == CLIENT_DC) ? dc_req_addr : ic_req_addr;

    assign req_fire     = mem_req_valid && mem_req_ready;
    assign wr_beat_fire = (state == WR_DATA) && mem_req_data_valid && mem_req_data_ready;
    assign resp_routed  = mem_resp_valid && !q_empty;
    assign q_push       = req_fire && !win_rw;
    assign q_pop        = resp_routed && (resp_cnt == LAST_BEAT);

    mem_arb_owner_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (q_push),
        .push_id(winner),
        .pop    (q_pop),
        .head   (q_head),
        .full   (q_full),
        .empty  (q_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_fire && win_rw) next_state = WR_DATA;
            WR_DATA: if (wr_beat_fire && (beat_cnt == LAST_BEAT)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid      = 1'b0;
        mem_req_addr       = win_addr;
        mem_req_rw         = win_rw;
        ic_req_ready       = 1'b0;
        dc_req_ready       = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = (wr_owner == CLIENT_DC) ? dc_req_data_bits : ic_req_data_bits;
        mem_req_data_mask  = (wr_owner == CLIENT_DC) ? dc_req_data_mask : ic_req_data_mask;
        ic_req_data_ready  = 1'b0;
        dc_req_data_ready  = 1'b0;
        ic_resp_valid      = resp_routed && (q_head == CLIENT_IC);
        dc_resp_valid      = resp_routed && (q_head == CLIENT_DC);
        ic_resp_data       = mem_resp_data;
        dc_resp_data       = mem_resp_data;
        if (state == IDLE) begin
            mem_req_valid = any_elig;
            ic_req_ready  = any_elig && (winner == CLIENT_IC) && mem_req_ready;
            dc_req_ready  = any_elig && (winner == CLIENT_DC) && mem_req_ready;
        end else begin
            mem_req_data_valid = (wr_owner == CLIENT_DC) ? dc_req_data_valid : ic_req_data_valid;
            ic_req_data_ready  = (wr_owner == CLIENT_IC) && mem_req_data_ready;
            dc_req_data_ready  = (wr_owner == CLIENT_DC) && mem_req_data_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_owner <= CLIENT_IC;
            beat_cnt <= '0;
            resp_cnt <= '0;
        end else begin
            if (req_fire && win_rw) begin
                wr_owner <= winner;
                beat_cnt <= '0;
            end else if (wr_beat_fire) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end
            if (resp_routed) begin
                resp_cnt <= (resp_cnt == LAST_BEAT) ? '0 : resp_cnt + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && mem_resp_valid && q_empty) begin
            $error("mem_arbiter: response beat dropped, no outstanding read");
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected requests,
// write beats and response beats; a negedge monitor pops and compares them.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = 16;
    localparam logic IC = 1'b0;
    localparam logic DC = 1'b1;

    typedef struct {
        logic          client;
        logic [AW-1:0] addr;
        logic          rw;
    } req_t;

    typedef struct {
        logic          client;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } wr_t;

    typedef struct {
        logic          client;
        logic [DW-1:0] data;
    } resp_t;

    req_t  exp_req[$];
    wr_t   exp_wr[$];
    resp_t exp_resp[$];
    req_t  mon_req;
    wr_t   mon_wr;
    resp_t mon_resp;

    int n_checks = 0;
    int n_fails  = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ic_req_valid, ic_req_ready, ic_req_rw;
    logic [AW-1:0] ic_req_addr;
    logic          ic_req_data_valid, ic_req_data_ready;
    logic [DW-1:0] ic_req_data_bits;
    logic [MW-1:0] ic_req_data_mask;
    logic          ic_resp_valid;
    logic [DW-1:0] ic_resp_data;
    logic          dc_req_valid, dc_req_ready, dc_req_rw;
    logic [AW-1:0] dc_req_addr;
    logic          dc_req_data_valid, dc_req_data_ready;
    logic [DW-1:0] dc_req_data_bits;
    logic [MW-1:0] dc_req_data_mask;
    logic          dc_resp_valid;
    logic [DW-1:0] dc_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_data_valid, mem_req_data_ready;
    logic [DW-1:0] mem_req_data_bits;
    logic [MW-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;

    logic          gseq [4];
    logic [AW-1:0] ic_a;
    logic [AW-1:0] dc_a;
    logic          pat [6];
    int            k;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .ic_req_valid      (ic_req_valid),
        .ic_req_ready      (ic_req_ready),
        .ic_req_addr       (ic_req_addr),
        .ic_req_rw         (ic_req_rw),
        .ic_req_data_valid (ic_req_data_valid),
        .ic_req_data_ready (ic_req_data_ready),
        .ic_req_data_bits  (ic_req_data_bits),
        .ic_req_data_mask  (ic_req_data_mask),
        .ic_resp_valid     (ic_resp_valid),
        .ic_resp_data      (ic_resp_data),
        .dc_req_valid      (dc_req_valid),
        .dc_req_ready      (dc_req_ready),
        .dc_req_addr       (dc_req_addr),
        .dc_req_rw         (dc_req_rw),
        .dc_req_data_valid (dc_req_data_valid),
        .dc_req_data_ready (dc_req_data_ready),
        .dc_req_data_bits  (dc_req_data_bits),
        .dc_req_data_mask  (dc_req_data_mask),
        .dc_resp_valid     (dc_resp_valid),
        .dc_resp_data      (dc_resp_data),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_req_rw        (mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits (mem_req_data_bits),
        .mem_req_data_mask (mem_req_data_mask),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data)
    );

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] wdata(input int idx);
        return DW'(32'hDA7A_0000 + idx);
    endfunction

    function automatic logic [MW-1:0] wmask(input int idx);
        return MW'(16'h00FF ^ idx);
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic client, input logic valid, input logic rw,
                                 input logic [AW-1:0] addr);
        if (client == DC) begin
            dc_req_valid = valid;
            dc_req_rw    = rw;
            dc_req_addr  = addr;
        end else begin
            ic_req_valid = valid;
            ic_req_rw    = rw;
            ic_req_addr  = addr;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(IC, 1'b0, 1'b0, '0);
        applyStimulus(DC, 1'b0, 1'b0, '0);
        ic_req_data_valid  = 1'b0;
        dc_req_data_valid  = 1'b0;
        ic_req_data_bits   = '0;
        dc_req_data_bits   = '0;
        ic_req_data_mask   = '0;
        dc_req_data_mask   = '0;
        mem_req_ready      = 1'b1;
        mem_req_data_ready = 1'b0;
        mem_resp_valid     = 1'b0;
        mem_resp_data      = '0;
        repeat (2) nextCycle();
        reset = 1'b0;
    endtask

    task automatic readReq(input logic client, input logic [AW-1:0] addr, input string name);
        applyStimulus(client, 1'b1, 1'b0, addr);
        exp_req.push_back('{client, addr, 1'b0});
        @(negedge clk);
        checkBit(name, (client == DC) ? dc_req_ready : ic_req_ready, 1'b1);
        nextCycle();
        applyStimulus(client, 1'b0, 1'b0, '0);
    endtask

    // Four response beats for the given owner; no request may issue meanwhile.
    task automatic respBurst(input logic client, input int base, input string name);
        for (int b = 0; b < 4; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = DW'(base + b);
            exp_resp.push_back('{client, DW'(base + b)});
            @(negedge clk);
            checkBit({name, "_other_quiet"}, (client == DC) ? ic_resp_valid : dc_resp_valid, 1'b0);
            checkBit({name, "_no_req"}, mem_req_valid, 1'b0);
            nextCycle();
        end
        mem_resp_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req_valid && mem_req_ready) begin
                if (exp_req.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL unexpected_req: got addr %0h, expected none", mem_req_addr);
                end else begin
                    mon_req = exp_req.pop_front();
                    checkBit("req_ready_onehot", ic_req_ready ^ dc_req_ready, 1'b1);
                    checkBit("req_client", dc_req_ready, mon_req.client);
                    checkOutput("req_addr", DW'(mem_req_addr), DW'(mon_req.addr));
                    checkBit("req_rw", mem_req_rw, mon_req.rw);
                end
            end
            if (mem_req_data_valid && mem_req_data_ready) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL unexpected_wr: got %0h, expected none", mem_req_data_bits);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    checkBit("wr_ready_onehot", ic_req_data_ready ^ dc_req_data_ready, 1'b1);
                    checkBit("wr_client", dc_req_data_ready, mon_wr.client);
                    checkOutput("wr_data", mem_req_data_bits, mon_wr.data);
                    checkOutput("wr_mask", DW'(mem_req_data_mask), DW'(mon_wr.mask));
                end
            end
            if (ic_resp_valid || dc_resp_valid) begin
                if (exp_resp.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL unexpected_resp: got %0h, expected none", mem_resp_data);
                end else begin
                    mon_resp = exp_resp.pop_front();
                    checkBit("resp_onehot", ic_resp_valid ^ dc_resp_valid, 1'b1);
                    checkBit("resp_client", dc_resp_valid, mon_resp.client);
                    checkOutput("resp_data", dc_resp_valid ? dc_resp_data : ic_resp_data, mon_resp.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();

        $display("[TB] reset state");
        @(negedge clk);
        checkBit("rst_mem_req_valid", mem_req_valid, 1'b0);
        checkBit("rst_mem_data_valid", mem_req_data_valid, 1'b0);
        checkBit("rst_ic_req_ready", ic_req_ready, 1'b0);
        checkBit("rst_dc_req_ready", dc_req_ready, 1'b0);
        checkBit("rst_ic_data_ready", ic_req_data_ready, 1'b0);
        checkBit("rst_dc_data_ready", dc_req_data_ready, 1'b0);
        checkBit("rst_ic_resp_valid", ic_resp_valid, 1'b0);
        checkBit("rst_dc_resp_valid", dc_resp_valid, 1'b0);
        nextCycle();

        $display("[TB] lone ic read");
        readReq(IC, 28'h0000010, "t1_ic_fire");
        respBurst(IC, 'hA0, "t1_resp");
        readReq(IC, 28'h0000011, "t1_queue_free_a");
        readReq(IC, 28'h0000012, "t1_queue_free_b");

        $display("[TB] simultaneous reads");
        doReset();
        applyStimulus(IC, 1'b1, 1'b0, 28'h20);
        applyStimulus(DC, 1'b1, 1'b0, 28'h30);
        exp_req.push_back('{DC, 28'h30, 1'b0});
        @(negedge clk);
        checkBit("t2_dc_first", dc_req_ready, 1'b1);
        checkBit("t2_ic_waits", ic_req_ready, 1'b0);
        nextCycle();
        applyStimulus(DC, 1'b0, 1'b0, '0);
        exp_req.push_back('{IC, 28'h20, 1'b0});
        @(negedge clk);
        checkBit("t2_ic_second", ic_req_ready, 1'b1);
        nextCycle();
        applyStimulus(IC, 1'b0, 1'b0, '0);
        respBurst(DC, 'hD0, "t2_dc_resp");
        respBurst(IC, 'h10, "t2_ic_resp");

        $display("[TB] continuous contention with full owner queue");
        doReset();
`ifdef MEM_ARB_RR_EN
        gseq = '{DC, IC, DC, IC};
`else
        gseq = '{DC, DC, DC, DC};
`endif
        ic_a = 28'h100;
        dc_a = 28'h200;
        for (int g = 0; g < 4; g++) begin
            applyStimulus(IC, 1'b1, 1'b0, ic_a);
            applyStimulus(DC, 1'b1, 1'b0, dc_a);
            exp_req.push_back('{gseq[g], (gseq[g] == DC) ? dc_a : ic_a, 1'b0});
            @(negedge clk);
            checkBit($sformatf("t3_grant%0d", g), (gseq[g] == DC) ? dc_req_ready : ic_req_ready, 1'b1);
            nextCycle();
            if (gseq[g] == DC) dc_a = dc_a + 1'b1;
            else ic_a = ic_a + 1'b1;
            if (g == 1 || g == 2) begin
                applyStimulus(IC, 1'b1, 1'b0, ic_a);
                applyStimulus(DC, 1'b1, 1'b0, dc_a);
                respBurst(gseq[g-1], 'h40 + 4 * (g - 1), $sformatf("t3_full%0d", g));
            end
        end
        applyStimulus(IC, 1'b0, 1'b0, '0);
        applyStimulus(DC, 1'b0, 1'b0, '0);
        respBurst(gseq[2], 'h48, "t3_drain2");
        respBurst(gseq[3], 'h4C, "t3_drain3");

        $display("[TB] dc write with data stalls");
        doReset();
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        mem_req_data_ready = 1'b1;
        applyStimulus(DC, 1'b1, 1'b1, 28'h300);
        applyStimulus(IC, 1'b1, 1'b0, 28'h40);
        dc_req_data_valid = 1'b1;
        dc_req_data_bits  = wdata(0);
        dc_req_data_mask  = wmask(0);
        ic_req_data_valid = 1'b1;
        ic_req_data_bits  = '1;
        ic_req_data_mask  = '1;
        exp_req.push_back('{DC, 28'h300, 1'b1});
        @(negedge clk);
        checkBit("t4_dc_wr_grant", dc_req_ready, 1'b1);
        checkBit("t4_idle_no_wdata", mem_req_data_valid, 1'b0);
        checkBit("t4_idle_no_dready", dc_req_data_ready, 1'b0);
        nextCycle();
        applyStimulus(DC, 1'b0, 1'b0, '0);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            mem_req_data_ready = pat[i];
            dc_req_data_bits   = wdata(k);
            dc_req_data_mask   = wmask(k);
            if (pat[i]) exp_wr.push_back('{DC, wdata(k), wmask(k)});
            @(negedge clk);
            checkBit($sformatf("t4_no_req%0d", i), mem_req_valid, 1'b0);
            checkBit($sformatf("t4_dc_dready%0d", i), dc_req_data_ready, pat[i]);
            checkBit($sformatf("t4_ic_dready%0d", i), ic_req_data_ready, 1'b0);
            nextCycle();
            if (pat[i]) k++;
        end
        mem_req_data_ready = 1'b1;
        dc_req_data_bits   = wdata(4);
        exp_req.push_back('{IC, 28'h40, 1'b0});
        @(negedge clk);
        checkBit("t4_ic_after_wr", ic_req_ready, 1'b1);
        checkBit("t4_idle_after_wr", mem_req_data_valid, 1'b0);
        nextCycle();
        applyStimulus(IC, 1'b0, 1'b0, '0);
        dc_req_data_valid = 1'b0;
        ic_req_data_valid = 1'b0;

        $display("[TB] reset during a write burst");
        doReset();
        mem_req_data_ready = 1'b1;
        readReq(IC, 28'h58, "t5_ic_read");
        applyStimulus(IC, 1'b1, 1'b1, 28'h5C);
        ic_req_data_valid = 1'b1;
        ic_req_data_bits  = wdata(10);
        ic_req_data_mask  = wmask(10);
        exp_req.push_back('{IC, 28'h5C, 1'b1});
        @(negedge clk);
        checkBit("t5_ic_write", ic_req_ready, 1'b1);
        nextCycle();
        applyStimulus(IC, 1'b0, 1'b0, '0);
        exp_wr.push_back('{IC, wdata(10), wmask(10)});
        mem_resp_valid = 1'b1;
        mem_resp_data  = DW'('hE0);
        exp_resp.push_back('{IC, DW'('hE0)});
        @(negedge clk);
        checkBit("t5_beat0_ready", ic_req_data_ready, 1'b1);
        nextCycle();
        mem_resp_valid   = 1'b0;
        ic_req_data_bits = wdata(11);
        ic_req_data_mask = wmask(11);
        exp_wr.push_back('{IC, wdata(11), wmask(11)});
        nextCycle();
        reset            = 1'b1;
        ic_req_data_bits = wdata(12);
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkBit("t5_mem_req_valid", mem_req_valid, 1'b0);
        checkBit("t5_mem_data_valid", mem_req_data_valid, 1'b0);
        checkBit("t5_ic_req_ready", ic_req_ready, 1'b0);
        checkBit("t5_dc_req_ready", dc_req_ready, 1'b0);
        checkBit("t5_ic_data_ready", ic_req_data_ready, 1'b0);
        checkBit("t5_dc_data_ready", dc_req_data_ready, 1'b0);
        checkBit("t5_ic_resp_valid", ic_resp_valid, 1'b0);
        checkBit("t5_dc_resp_valid", dc_resp_valid, 1'b0);
        nextCycle();
        ic_req_data_valid = 1'b0;
        readReq(DC, 28'h60, "t5_dc_after_reset");
        respBurst(DC, 'hF0, "t5_resp");

        repeat (3) nextCycle();
        checkBit("req_queue_drained", exp_req.size() == 0, 1'b1);
        checkBit("wr_queue_drained", exp_wr.size() == 0, 1'b1);
        checkBit("resp_queue_drained", exp_resp.size() == 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
